// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx, finds the start bit on the 16x tick,
// samples data bits at mid-bit into the SIPO and checks the stop bit.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx,
  output logic shift_en,
  output logic shift_bit,
  output logic rx_done,
  output logic frame_err,
  output logic busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a tick with rx_s low
  // START | counting to mid start bit to confirm it
  // DATA  | sampling DATA_BITS data bits at mid-bit, LSB first
  // STOP  | waiting for mid stop bit, then reporting the frame
  // BREAK | stop bit was low; wait for the line to go high again

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          rx_meta, rx_s;
  logic          shift_en_nxt, shift_bit_nxt, rx_done_nxt, frame_err_nxt, busy_nxt;

  // rx is asynchronous to clk; both stages reset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_en  <= 1'b0;
      shift_bit <= 1'b1;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_en  <= shift_en_nxt;
      shift_bit <= shift_bit_nxt;
      rx_done   <= rx_done_nxt;
      frame_err <= frame_err_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_en_nxt  = 1'b0;
    shift_bit_nxt = shift_bit;
    rx_done_nxt   = 1'b0;
    frame_err_nxt = frame_err;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt_nxt   = '0;
            state_nxt = START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              bit_cnt_nxt = '0;
              state_nxt   = DATA;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            shift_en_nxt  = 1'b1;
            shift_bit_nxt = rx_s;
            cnt_nxt       = '0;
            bit_cnt_nxt   = bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state_nxt = STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            rx_done_nxt   = 1'b1;
            frame_err_nxt = !rx_s;
            cnt_nxt       = '0;
            state_nxt     = rx_s ? IDLE : BREAK;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // busy is registered alongside the state so it tracks the state register exactly
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART: watches the serial line using the 16x oversampling tick, finds the start bit and samples each data bit at mid-bit. It drives the shift enable and serial bit into the 8-bit SIPO receive shift register, then checks the stop bit. It sits between the baud tick generator / `rx` pin and the SIPO, and reports frame completion and framing errors to the host side.

## Interface
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥4.
- `DATA_BITS`, 8: data bits per frame; must match SIPO depth.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  oversample enable, one `clk` cycle wide, OVERSAMPLE × baud.
- `rx`  in  1  raw serial line, idle high, asynchronous.
- `shift_en`  out  1  one-cycle strobe: SIPO shifts `shift_bit` in.
- `shift_bit`  out  1  sampled data bit, valid while `shift_en`=1.
- `rx_done`  out  1  one-cycle pulse: frame finished (good or bad stop).
- `frame_err`  out  1  stop bit sampled low; updated with `rx_done`.
- `busy`  out  1  high from start detect until return to IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`); both stages reset to 1. All decisions use `rx_s`.
- Tick counter `cnt` is $clog2(OVERSAMPLE) bits. Bit counter `bit_cnt` is $clog2(DATA_BITS+1) bits. Both advance only on `tick`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `tick` with `rx_s`=0, clear `cnt`, set `busy`, go to START.
- START: on each `tick`, increment `cnt`.
  - On `tick` with `cnt`=OVERSAMPLE/2-1 and `rx_s`=0: clear `cnt` and `bit_cnt`, go to DATA.
  - On that tick with `rx_s`=1: false start. Go to IDLE, `busy`=0, no strobes.
- DATA: on each `tick`, increment `cnt`.
  - On `tick` with `cnt`=OVERSAMPLE-1: pulse `shift_en`, set `shift_bit`=`rx_s`, clear `cnt`, increment `bit_cnt`.
  - After strobe number DATA_BITS, go to STOP. Bits are shifted LSB first.
- STOP: on `tick` with `cnt`=OVERSAMPLE-1, sample `rx_s`, pulse `rx_done`, set `frame_err`=!`rx_s`.
  - Stop high: go to IDLE.
  - Stop low: go to BREAK.
- BREAK: stay (`busy`=1) until a `tick` with `rx_s`=1, then go to IDLE. A held-low line never starts a new frame.
- `frame_err` holds its value until the next `rx_done`.
- No `tick`: the FSM and counters hold; outputs keep their values, except the strobes, which fall after one cycle.

## Timing
- Reset values: state IDLE, `cnt`=0, `bit_cnt`=0, `shift_en`=0, `shift_bit`=1, `rx_done`=0, `frame_err`=0, `busy`=0.
- All outputs are registered. `shift_en` and `rx_done` assert in the `clk` cycle after the qualifying `tick` cycle and last exactly one cycle.
- Sampling from the first tick with `rx_s`=0:
  - start check at +OVERSAMPLE/2 ticks;
  - data bit k (0-based) at +OVERSAMPLE/2 + (k+1)·OVERSAMPLE ticks;
  - stop at +OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks.
- Input latency: 2 `clk` cycles of synchronizer delay from `rx` to `rx_s`.
- `busy` rises the cycle after start detection. It falls the cycle after `rx_done` on a good frame, or after leaving BREAK.
- A new start is accepted on the first `tick` in IDLE. Back-to-back frames with one stop bit are supported.
- Reset asserted mid-frame: all registers return to their reset values immediately (asynchronous). No `rx_done` is issued for the aborted frame.
- `tick` coinciding with reset deassertion is ignored.

## Test plan
- Good frame: tick every 4 clk, send 0xA5 (LSB first, stop=1) → exactly 8 `shift_en` pulses with `shift_bit` = 1,0,1,0,0,1,0,1. One `rx_done`, `frame_err`=0. `shift_en` pulses are 16 ticks apart; first pulse 24 ticks after detection.
- False start: drive `rx` low for 4 ticks, then high → no `shift_en`, no `rx_done`. `busy` returns to 0 at the tick-8 check.
- Framing error: send 0x3C with stop=0, then hold `rx` low for 40 ticks, then release → `rx_done` with `frame_err`=1. FSM stays in BREAK, no new frame while low. IDLE is reached on the first tick after release.
- Back-to-back: 0x00 then 0xFF with no idle gap → 16 `shift_en` pulses, 2 `rx_done`, `frame_err`=0 both times.
- Reset mid-frame: assert `rst` after the 3rd `shift_en` of a frame → all outputs at reset values within the same cycle. The next full frame 0x5A is received correctly.
- Tick stall: stop `tick` for 50 clk mid-DATA → no strobes during the stall. The frame completes correctly once `tick` resumes.
